// File: rtl/stq_alloc_ctl.sv
// Store-queue allocation controller: alloc (A), retire (P) and free (F) pointers over a 64-entry address buffer.
// Optional high-water-mark output `hwm` is built when STQ_ALLOC_CTL_HWM_EN is defined.
module stq_alloc_ctl (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallA,
  input  logic        excpt,
  input  logic [1:0]  alloc_req,
  output logic        alloc_gnt,
  output logic [5:0]  alloc_idx0,
  output logic [5:0]  alloc_idx1,
  input  logic [1:0]  retire_cnt,
  output logic        drain_vld,
  output logic [5:0]  drain_idx,
  input  logic        drain_ack,
  output logic [63:0] wrt0_en,
  output logic [63:0] wrt1_en,
  output logic [63:0] passe_en,
  output logic [63:0] free_en,
  output logic        full,
  output logic        empty,
  output logic [6:0]  count,
`ifdef STQ_ALLOC_CTL_HWM_EN
  output logic [6:0]  hwm,
`endif
  output logic        err
);

  localparam int unsigned DEPTH = 64;
  localparam int unsigned IDX_W = 6;
  localparam int unsigned PTR_W = 7;

  logic [PTR_W-1:0] r_a;
  logic [PTR_W-1:0] r_p;
  logic [PTR_W-1:0] r_f;
  logic             r_err;

  logic [PTR_W-1:0] w_a_nxt;
  logic [PTR_W-1:0] w_p_nxt;
  logic [PTR_W-1:0] w_f_nxt;
  logic             w_err_nxt;

  logic [PTR_W-1:0] w_count;
  logic [PTR_W-1:0] w_space;
  logic [PTR_W-1:0] w_req_n;
  logic [PTR_W-1:0] w_ret_n;
  logic [PTR_W-1:0] w_inflight;
  logic [PTR_W-1:0] w_flush_n;
  logic [IDX_W-1:0] w_a_idx1;
  logic [IDX_W-1:0] w_p_idx1;
  logic             w_gnt;
  logic             w_ret_ok;
  logic             w_drain_vld;
  logic             w_drain_fire;
  logic             w_ack_err;
  logic [DEPTH-1:0] w_flush_mask;
  logic [DEPTH-1:0] w_drain_mask;

  // Occupancy and free space come from registered pointers only, so a slot
  // freed this cycle cannot be re-granted until the next cycle.
  assign w_count    = r_a - r_f;
  assign w_space    = PTR_W'(DEPTH) - w_count;
  assign w_req_n    = PTR_W'(alloc_req[0]) + PTR_W'(alloc_req[1]);
  assign w_ret_n    = PTR_W'(retire_cnt);
  assign w_inflight = r_a - r_p;
  assign w_a_idx1   = r_a[IDX_W-1:0] + IDX_W'(1);
  assign w_p_idx1   = r_p[IDX_W-1:0] + IDX_W'(1);

  // A lone bit1 request is malformed and never granted.
  assign w_gnt = ~rst & alloc_req[0] & ~stallA & ~excpt & (w_space >= w_req_n);

  assign w_ret_ok     = (retire_cnt != 2'd3) & (w_ret_n <= w_inflight);
  assign w_drain_vld  = (r_f != r_p);
  assign w_drain_fire = ~rst & drain_ack & w_drain_vld;
  assign w_ack_err    = drain_ack & ~w_drain_vld;

  // Next-state for the three pointers and the sticky error flag.
  always_comb begin
    w_p_nxt   = r_p;
    w_f_nxt   = r_f;
    w_a_nxt   = r_a;
    w_err_nxt = r_err;
    if (w_ret_ok) begin
      w_p_nxt = r_p + w_ret_n;
    end
    if (w_drain_fire) begin
      w_f_nxt = r_f + PTR_W'(1);
    end
    if (excpt) begin
      w_a_nxt = w_p_nxt;
    end else if (w_gnt) begin
      w_a_nxt = r_a + w_req_n;
    end
    if (!w_ret_ok || w_ack_err) begin
      w_err_nxt = 1'b1;
    end
  end

  // Flush frees every speculative slot in [P', A), measured as offset from P'.
  assign w_flush_n = r_a - w_p_nxt;

  always_comb begin
    w_flush_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_flush_mask[i] = excpt &
        ({1'b0, IDX_W'(i) - w_p_nxt[IDX_W-1:0]} < w_flush_n);
    end
  end

  assign w_drain_mask = w_drain_fire ? (DEPTH'(1) << r_f[IDX_W-1:0]) : '0;

  always_comb begin
    passe_en = '0;
    if (!rst && w_ret_ok && retire_cnt != 2'd0) begin
      passe_en[r_p[IDX_W-1:0]] = 1'b1;
      if (retire_cnt == 2'd2) begin
        passe_en[w_p_idx1] = 1'b1;
      end
    end
  end

  assign alloc_gnt  = w_gnt;
  assign alloc_idx0 = r_a[IDX_W-1:0];
  assign alloc_idx1 = w_a_idx1;
  assign wrt0_en    = w_gnt ? (DEPTH'(1) << r_a[IDX_W-1:0]) : '0;
  assign wrt1_en    = (w_gnt && alloc_req[1]) ? (DEPTH'(1) << w_a_idx1) : '0;
  assign free_en    = rst ? '0 : (w_flush_mask | w_drain_mask);
  assign drain_vld  = ~rst & w_drain_vld;
  assign drain_idx  = r_f[IDX_W-1:0];
  assign count      = w_count;
  assign full       = (w_count == PTR_W'(DEPTH));
  assign empty      = (w_count == '0);
  assign err        = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_p   <= '0;
      r_f   <= '0;
      r_err <= 1'b0;
    end else begin
      r_a   <= w_a_nxt;
      r_p   <= w_p_nxt;
      r_f   <= w_f_nxt;
      r_err <= w_err_nxt;
    end
  end

`ifdef STQ_ALLOC_CTL_HWM_EN
  logic [PTR_W-1:0] r_hwm;
  logic [PTR_W-1:0] w_cnt_nxt;

  assign w_cnt_nxt = w_a_nxt - w_f_nxt;

  // Tracks the peak occupancy reached after each edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hwm <= '0;
    end else if (w_cnt_nxt > r_hwm) begin
      r_hwm <= w_cnt_nxt;
    end
  end

  assign hwm = r_hwm;
`endif

endmodule

// File: tb/tb_stq_alloc_ctl.sv
// Self-checking bench for stq_alloc_ctl: directed scenarios plus randomized traffic against an unbounded-counter model.
module tb_stq_alloc_ctl;

  logic        clk;
  logic        rst;
  logic        stallA;
  logic        excpt;
  logic [1:0]  alloc_req;
  logic        alloc_gnt;
  logic [5:0]  alloc_idx0;
  logic [5:0]  alloc_idx1;
  logic [1:0]  retire_cnt;
  logic        drain_vld;
  logic [5:0]  drain_idx;
  logic        drain_ack;
  logic [63:0] wrt0_en;
  logic [63:0] wrt1_en;
  logic [63:0] passe_en;
  logic [63:0] free_en;
  logic        full;
  logic        empty;
  logic [6:0]  count;
  logic        err;
`ifdef STQ_ALLOC_CTL_HWM_EN
  logic [6:0]  hwm;
`endif

  int checks;
  int failures;

  // Model: total allocations/retirements/frees since reset as plain integers.
  int m_a, m_p, m_f, m_hwm;
  bit m_err;

  logic        e_gnt, e_drain_vld, e_full, e_empty;
  logic [5:0]  e_idx0, e_idx1, e_drain_idx;
  logic [6:0]  e_count;
  logic [63:0] e_wrt0, e_wrt1, e_passe, e_free;

  stq_alloc_ctl dut (
    .clk(clk), .rst(rst), .stallA(stallA), .excpt(excpt),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt),
    .alloc_idx0(alloc_idx0), .alloc_idx1(alloc_idx1),
    .retire_cnt(retire_cnt), .drain_vld(drain_vld), .drain_idx(drain_idx),
    .drain_ack(drain_ack), .wrt0_en(wrt0_en), .wrt1_en(wrt1_en),
    .passe_en(passe_en), .free_en(free_en), .full(full), .empty(empty),
    .count(count),
`ifdef STQ_ALLOC_CTL_HWM_EN
    .hwm(hwm),
`endif
    .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int req_n(input logic [1:0] r);
    return (r == 2'b11) ? 2 : (r == 2'b01) ? 1 : 0;
  endfunction

  task automatic compute_expect();
    int cnt, n, rc, pn;
    bit ok;
    cnt = m_a - m_f;
    n = req_n(alloc_req);
    rc = int'(retire_cnt);
    e_count = 7'(cnt);
    e_full = (cnt == 64);
    e_empty = (cnt == 0);
    e_drain_vld = (m_f != m_p);
    e_drain_idx = 6'(m_f % 64);
    e_idx0 = 6'(m_a % 64);
    e_idx1 = 6'((m_a + 1) % 64);
    e_gnt = (n != 0) && !stallA && !excpt && (64 - cnt >= n);
    e_wrt0 = '0;
    e_wrt1 = '0;
    if (e_gnt) e_wrt0[m_a % 64] = 1'b1;
    if (e_gnt && n == 2) e_wrt1[(m_a + 1) % 64] = 1'b1;
    ok = (rc <= 2) && (rc <= m_a - m_p);
    e_passe = '0;
    if (ok) for (int k = 0; k < rc; k++) e_passe[(m_p + k) % 64] = 1'b1;
    pn = ok ? m_p + rc : m_p;
    e_free = '0;
    if (drain_ack && m_f != m_p) e_free[m_f % 64] = 1'b1;
    if (excpt) for (int k = pn; k < m_a; k++) e_free[k % 64] = 1'b1;
  endtask

  task automatic model_step();
    int rc, pn;
    bit ok, fire;
    if (rst) begin
      m_a = 0; m_p = 0; m_f = 0; m_hwm = 0; m_err = 1'b0;
      return;
    end
    compute_expect();
    rc = int'(retire_cnt);
    ok = (rc <= 2) && (rc <= m_a - m_p);
    pn = ok ? m_p + rc : m_p;
    fire = drain_ack && (m_f != m_p);
    if (!ok || (drain_ack && !fire)) m_err = 1'b1;
    if (excpt) m_a = pn;
    else if (e_gnt) m_a = m_a + req_n(alloc_req);
    m_p = pn;
    if (fire) m_f = m_f + 1;
    if (m_a - m_f > m_hwm) m_hwm = m_a - m_f;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    stallA = 1'b0; excpt = 1'b0; alloc_req = 2'b00;
    retire_cnt = 2'd0; drain_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    alloc_req = 2'b11; drain_ack = 1'b1; excpt = 1'b1; retire_cnt = 2'd1;
    tick();
    #1;
    checks++; if (count !== 7'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_flags empty=%b full=%b exp 1/0", empty, full); end
    checks++; if (drain_vld !== 1'b0 || alloc_gnt !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL reset_ctl dv=%b gnt=%b err=%b exp 0", drain_vld, alloc_gnt, err); end
    checks++; if ((wrt0_en | wrt1_en | passe_en | free_en) !== 64'd0) begin failures++; $display("FAIL reset_en got=%h exp=0", wrt0_en | wrt1_en | passe_en | free_en); end
    rst = 1'b0;
    idle();
    tick();
  endtask

  task automatic test_basic();
    do_reset();
    alloc_req = 2'b11; stallA = 1'b1;
    #1;
    checks++; if (alloc_gnt !== 1'b0 || wrt0_en !== 64'd0) begin failures++; $display("FAIL stall_gnt gnt=%b wrt0=%h exp 0", alloc_gnt, wrt0_en); end
    tick();
    stallA = 1'b0;
    #1;
    checks++; if (alloc_gnt !== 1'b1) begin failures++; $display("FAIL basic_gnt got=%b exp=1", alloc_gnt); end
    checks++; if (wrt0_en !== 64'h1 || wrt1_en !== 64'h2) begin failures++; $display("FAIL basic_wrt wrt0=%h wrt1=%h exp 1/2", wrt0_en, wrt1_en); end
    checks++; if (alloc_idx0 !== 6'd0 || alloc_idx1 !== 6'd1) begin failures++; $display("FAIL basic_idx %0d/%0d exp 0/1", alloc_idx0, alloc_idx1); end
    tick();
    idle();
    #1;
    checks++; if (count !== 7'd2 || empty !== 1'b0) begin failures++; $display("FAIL basic_count count=%0d empty=%b exp 2/0", count, empty); end
    checks++; if (alloc_idx0 !== 6'd2) begin failures++; $display("FAIL basic_adv idx0=%0d exp=2", alloc_idx0); end
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k < 31; k++) begin alloc_req = 2'b11; tick(); end
    alloc_req = 2'b01; tick();
    idle();
    #1;
    checks++; if (count !== 7'd63 || full !== 1'b0) begin failures++; $display("FAIL fill63 count=%0d full=%b exp 63/0", count, full); end
    alloc_req = 2'b11;
    #1;
    checks++; if (alloc_gnt !== 1'b0 || (wrt0_en | wrt1_en) !== 64'd0) begin failures++; $display("FAIL full_pair gnt=%b wrt=%h exp 0", alloc_gnt, wrt0_en | wrt1_en); end
    alloc_req = 2'b01;
    #1;
    checks++; if (alloc_gnt !== 1'b1 || wrt0_en !== (64'd1 << 63)) begin failures++; $display("FAIL full_single gnt=%b wrt0=%h", alloc_gnt, wrt0_en); end
    tick();
    #1;
    checks++; if (full !== 1'b1 || count !== 7'd64) begin failures++; $display("FAIL full_flag full=%b count=%0d exp 1/64", full, count); end
    checks++; if (alloc_gnt !== 1'b0) begin failures++; $display("FAIL full_nogrant got=%b exp=0", alloc_gnt); end
    idle();
  endtask

  task automatic test_drain();
    do_reset();
    alloc_req = 2'b11; tick(); tick();
    alloc_req = 2'b01; tick();
    idle();
    retire_cnt = 2'd2; tick(); tick();
    retire_cnt = 2'd1; tick();
    idle();
    drain_ack = 1'b1; tick(); tick(); tick();
    idle();
    #1;
    checks++; if (count !== 7'd2 || drain_vld !== 1'b1 || drain_idx !== 6'd3) begin failures++; $display("FAIL drain_setup count=%0d dv=%b idx=%0d exp 2/1/3", count, drain_vld, drain_idx); end
    drain_ack = 1'b1;
    #1;
    checks++; if (free_en !== (64'd1 << 3)) begin failures++; $display("FAIL drain_free3 got=%h", free_en); end
    tick();
    #1;
    checks++; if (free_en !== (64'd1 << 4)) begin failures++; $display("FAIL drain_free4 got=%h", free_en); end
    tick();
    #1;
    checks++; if (empty !== 1'b1 || drain_vld !== 1'b0) begin failures++; $display("FAIL drain_empty empty=%b dv=%b exp 1/0", empty, drain_vld); end
    checks++; if (free_en !== 64'd0) begin failures++; $display("FAIL stray_ack_free got=%h exp=0", free_en); end
    tick();
    idle();
    #1;
    checks++; if (err !== 1'b1 || count !== 7'd0) begin failures++; $display("FAIL stray_ack_err err=%b count=%0d exp 1/0", err, count); end
  endtask

  task automatic test_flush();
    do_reset();
    for (int k = 0; k < 5; k++) begin alloc_req = 2'b11; tick(); end
    idle();
    for (int k = 0; k < 3; k++) begin retire_cnt = 2'd2; tick(); end
    idle();
    excpt = 1'b1; retire_cnt = 2'd1; alloc_req = 2'b11;
    #1;
    checks++; if (alloc_gnt !== 1'b0 || wrt0_en !== 64'd0) begin failures++; $display("FAIL flush_nogrant gnt=%b wrt0=%h", alloc_gnt, wrt0_en); end
    checks++; if (passe_en !== (64'd1 << 6)) begin failures++; $display("FAIL flush_passe got=%h exp=%h", passe_en, 64'd1 << 6); end
    checks++; if (free_en !== 64'h380) begin failures++; $display("FAIL flush_free got=%h exp=380", free_en); end
    tick();
    idle();
    #1;
    checks++; if (count !== 7'd7 || alloc_idx0 !== 6'd7) begin failures++; $display("FAIL flush_a count=%0d idx0=%0d exp 7/7", count, alloc_idx0); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL flush_err got=%b exp=0", err); end
    retire_cnt = 2'd1;
    #1;
    checks++; if (passe_en !== 64'd0) begin failures++; $display("FAIL flush_p_eq_a passe=%h exp=0", passe_en); end
    tick();
    idle();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 400 && m_a < 126; k++) begin
      alloc_req = 2'b01;
      retire_cnt = (m_a > m_p) ? 2'd1 : 2'd0;
      drain_ack = (m_f < m_p) && (m_f < 100);
      tick();
    end
    idle();
    #1;
    checks++; if (count !== 7'd26 || drain_idx !== 6'd36) begin failures++; $display("FAIL wrap_setup count=%0d drain_idx=%0d exp 26/36", count, drain_idx); end
    alloc_req = 2'b11;
    #1;
    checks++; if (alloc_gnt !== 1'b1 || alloc_idx0 !== 6'd62 || alloc_idx1 !== 6'd63) begin failures++; $display("FAIL wrap_idx_a gnt=%b idx=%0d/%0d exp 1 62/63", alloc_gnt, alloc_idx0, alloc_idx1); end
    checks++; if (wrt0_en !== (64'd1 << 62) || wrt1_en !== (64'd1 << 63)) begin failures++; $display("FAIL wrap_wrt_a wrt0=%h wrt1=%h", wrt0_en, wrt1_en); end
    tick();
    #1;
    checks++; if (alloc_gnt !== 1'b1 || alloc_idx0 !== 6'd0 || alloc_idx1 !== 6'd1 || count !== 7'd28) begin failures++; $display("FAIL wrap_idx_b gnt=%b idx=%0d/%0d count=%0d", alloc_gnt, alloc_idx0, alloc_idx1, count); end
    checks++; if (wrt0_en !== 64'h1 || wrt1_en !== 64'h2) begin failures++; $display("FAIL wrap_wrt_b wrt0=%h wrt1=%h", wrt0_en, wrt1_en); end
    tick();
    idle();
    #1;
    checks++; if (count !== 7'd30 || alloc_idx0 !== 6'd2) begin failures++; $display("FAIL wrap_after count=%0d idx0=%0d exp 30/2", count, alloc_idx0); end
  endtask

  task automatic test_retire_err();
    do_reset();
    alloc_req = 2'b01; tick();
    idle();
    retire_cnt = 2'd2;
    #1;
    checks++; if (passe_en !== 64'd0) begin failures++; $display("FAIL rerr_passe got=%h exp=0", passe_en); end
    tick();
    idle();
    #1;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL rerr_err got=%b exp=1", err); end
    retire_cnt = 2'd1;
    #1;
    checks++; if (passe_en !== 64'h1) begin failures++; $display("FAIL rerr_p_kept passe=%h exp=1", passe_en); end
    tick();
    idle();
    tick();
    #1;
    checks++; if (err !== 1'b1 || drain_vld !== 1'b1) begin failures++; $display("FAIL rerr_sticky err=%b dv=%b exp 1/1", err, drain_vld); end
    do_reset();
    #1;
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL rerr_clear got=%b exp=0", err); end
  endtask

  task automatic test_random();
    int avail, rc;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rst = ($urandom_range(0, 199) == 0);
      stallA = ($urandom_range(0, 7) == 0);
      excpt = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0: alloc_req = 2'b00;
        1: alloc_req = 2'b01;
        default: alloc_req = 2'b11;
      endcase
      avail = m_a - m_p;
      rc = $urandom_range(0, 2);
      if (rc > avail && $urandom_range(0, 29) != 0) rc = avail;
      retire_cnt = 2'(rc);
      drain_ack = ($urandom_range(0, 9) < 6) && ((m_f != m_p) || $urandom_range(0, 29) == 0);
      #1;
      if (!rst) begin
        compute_expect();
        checks++; if (alloc_gnt !== e_gnt) begin failures++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, alloc_gnt, e_gnt); end
        checks++; if (alloc_idx0 !== e_idx0 || alloc_idx1 !== e_idx1) begin failures++; $display("FAIL rnd_idx cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, alloc_idx0, alloc_idx1, e_idx0, e_idx1); end
        checks++; if (wrt0_en !== e_wrt0 || wrt1_en !== e_wrt1) begin failures++; $display("FAIL rnd_wrt cyc=%0d got=%h/%h exp=%h/%h", cyc, wrt0_en, wrt1_en, e_wrt0, e_wrt1); end
        checks++; if (passe_en !== e_passe) begin failures++; $display("FAIL rnd_passe cyc=%0d got=%h exp=%h", cyc, passe_en, e_passe); end
        checks++; if (free_en !== e_free) begin failures++; $display("FAIL rnd_free cyc=%0d got=%h exp=%h", cyc, free_en, e_free); end
        checks++; if (drain_vld !== e_drain_vld || drain_idx !== e_drain_idx) begin failures++; $display("FAIL rnd_drain cyc=%0d got=%b/%0d exp=%b/%0d", cyc, drain_vld, drain_idx, e_drain_vld, e_drain_idx); end
        checks++; if (count !== e_count || full !== e_full || empty !== e_empty) begin failures++; $display("FAIL rnd_count cyc=%0d got=%0d/%b/%b exp=%0d/%b/%b", cyc, count, full, empty, e_count, e_full, e_empty); end
        checks++; if (err !== m_err) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", cyc, err, m_err); end
`ifdef STQ_ALLOC_CTL_HWM_EN
        checks++; if (hwm !== 7'(m_hwm)) begin failures++; $display("FAIL rnd_hwm cyc=%0d got=%0d exp=%0d", cyc, hwm, m_hwm); end
`endif
      end
      tick();
    end
    idle();
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    m_a = 0; m_p = 0; m_f = 0; m_hwm = 0; m_err = 1'b0;
    rst = 1'b1;
    idle();
    test_reset();
    test_basic();
    test_full();
    test_drain();
    test_flush();
    test_wrap();
    test_retire_err();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stq_alloc_ctl.md
STQ_ALLOC_CTL -- requirements
Module: stq_alloc_ctl

Interface
REQ-001 SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-002 SHALL have port rst, input, 1, reset: synchronous, active-high; clock clk.
REQ-003 SHALL have port stallA, input, 1, suppresses allocation in the current cycle.
REQ-004 SHALL have port excpt, input, 1, pipeline flush: discards all non-retired entries.
REQ-005 SHALL have port alloc_req, input, 2, store allocation requests; bit1 only valid with bit0.
REQ-006 SHALL have port alloc_gnt, output, 1, all-or-nothing grant of alloc_req this cycle.
REQ-007 SHALL have port alloc_idx0/alloc_idx1, output, 6 each, slot indices granted to requests 0/1.
REQ-008 SHALL have port retire_cnt, input, 2, count of oldest stores committed this cycle (0..2).
REQ-009 SHALL have port drain_vld, output, 1, a retired entry awaits drain to cache.
REQ-010 SHALL have port drain_idx, output, 6, index of oldest retired entry.
REQ-011 SHALL have port drain_ack, input, 1, cache accepted drain_idx this cycle.
REQ-012 SHALL have ports wrt0_en, wrt1_en, passe_en, free_en, output, 64 each, per-slot enables to the 64-entry address buffer array.
REQ-013 SHALL have ports full, empty, output, 1 each; count, output, 7, occupied slots (0..64).
REQ-014 SHALL have port err, output, 1, sticky protocol-violation flag.

Function
REQ-015 SHALL keep three 7-bit pointers (bit6 = wrap): alloc A, retire P, free F; invariant F <= P <= A modulo 128; slot = pointer[5:0].
REQ-016 SHALL compute count = A - F (7-bit), full = (count == 64), empty = (count == 0), all from registered state.
REQ-017 SHALL assert alloc_gnt combinationally when alloc_req != 0, ~stallA, ~excpt, and 64 - count >= popcount(alloc_req).
REQ-018 SHALL drive wrt0_en one-hot at A[5:0] when granted and alloc_req[0]; wrt1_en one-hot at (A+1)[5:0] when granted and alloc_req[1]; else zero.
REQ-019 SHALL set alloc_idx0 = A[5:0], alloc_idx1 = (A+1)[5:0] regardless of grant; A advances by popcount on the next edge only if granted.
REQ-020 SHALL drive passe_en one-hot bits at P[5:0] and (P+1)[5:0] for retire_cnt = 1 or 2; P advances by retire_cnt.
REQ-021 SHALL, if retire_cnt > A - P, ignore the retire entirely and set err.
REQ-022 SHALL drive drain_vld = (F != P) and drain_idx = F[5:0]; on drain_vld & drain_ack drive free_en one-hot at F[5:0] and advance F by 1.
REQ-023 SHALL, on drain_ack without drain_vld, ignore it and set err.
REQ-024 SHALL, on excpt, first apply that cycle's retire (P' = P + retire_cnt), then set A <= P', and assert free_en for every slot in [P', A) modulo wrap, ORed with any drain free_en.
REQ-025 SHALL suppress allocation whenever excpt is high (excpt priority over alloc_req).
REQ-026 SHALL wrap all pointers modulo 128; equal [5:0] with differing bit6 means full.
REQ-027 SHALL allow alloc, retire, and drain in the same cycle; a slot freed this cycle becomes allocatable next cycle only.

Reset
REQ-028 SHALL, on rst, clear A, P, F, and err; outputs: count=0, empty=1, full=0, drain_vld=0, alloc_gnt=0, all enable vectors zero.
REQ-029 SHALL, on rst mid-operation, abandon all entries without asserting free_en (buffer array resets itself).

Configuration
REQ-030 SHALL, with macro STQ_ALLOC_CTL_HWM_EN defined, provide output hwm (7 bits): maximum count since reset, updated each edge, cleared by rst.
REQ-031 SHALL, without STQ_ALLOC_CTL_HWM_EN, omit the hwm port and its register; all other behaviour SHALL be identical.

Verification
REQ-032 Reset then alloc_req=2'b11 -> alloc_gnt=1, wrt0_en bit0, wrt1_en bit1; next cycle count=2, empty=0.
REQ-033 Fill to count=63, alloc_req=2'b11 -> alloc_gnt=0, wrt*_en zero; alloc_req=2'b01 -> grant, then full=1.
REQ-034 A=P=5, F=3: drain_ack twice -> free_en bits 3 then 4, empty=1 after.
REQ-035 A=10, P=6, excpt with retire_cnt=1 -> passe_en bit6; free_en bits 7..9; next A=7, P=7.
REQ-036 A=126 (slot 62), alloc_req=2'b11 twice with F at 100 -> slots 62, 63, 0, 1 granted; pointer bit6 toggles.
REQ-037 retire_cnt=2 with A-P=1 -> passe_en zero, P unchanged, err=1 until rst.
